// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue.
package wb_pkg;
    localparam int DATA_W = 64;
    localparam int IDX_W  = 6;
    localparam logic [IDX_W-1:0] REG_ZERO = '0;

    // One pending register-file write: destination index plus result.
    typedef struct packed {
        logic [IDX_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer with two write ports (wr0 older than wr1) and an
// implicit read port: the head is popped on every cycle the buffer is non-empty.
// All slots are exposed so the owner can run a bypass compare.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr0_en,
    input  wb_entry_t        wr0_entry,
    input  logic             wr1_en,
    input  wb_entry_t        wr1_entry,
    output logic             deq,
    output wb_entry_t        head,
    output wb_entry_t        entries [DEPTH],
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);
    wb_entry_t        mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] wr1_slot;
    logic [DEPTH-1:0] slot_wr0;
    logic [DEPTH-1:0] slot_wr1;

    // The head leaves whenever anything is stored.
    assign deq      = (count_reg != '0);
    // wr1 lands right behind wr0 when both write, otherwise at the tail.
    assign wr1_slot = wr_ptr_reg + PTR_W'(wr0_en);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slot_wr0[gi] = wr0_en && (wr_ptr_reg == PTR_W'(gi));
            assign slot_wr1[gi] = wr1_en && (wr1_slot == PTR_W'(gi));
            assign entries[gi]  = mem_reg[gi];
        end
    endgenerate

    assign head       = mem_reg[rd_ptr_reg];
    assign rd_ptr     = rd_ptr_reg;
    assign count      = count_reg;
    assign count_next = count_reg + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(deq);

    // Slot storage: payload only, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_wr0[i]) begin
                mem_reg[i] <= wr0_entry;
            end else if (slot_wr1[i]) begin
                mem_reg[i] <= wr1_entry;
            end
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(deq);
            count_reg  <= count_next;
        end
    end
endmodule

// File: rtl/wb_queue.sv
// Writeback queue: arbitrates ALU/load results into an in-order FIFO, drains
// one entry per cycle onto the register-file write port, and offers a
// youngest-match bypass over everything not yet committed.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int IDX_W  = wb_pkg::IDX_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [IDX_W-1:0]         alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [IDX_W-1:0]         mem_rd,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    output logic                     RegWrite,
    output logic [IDX_W-1:0]         rd,
    output logic [DATA_W-1:0]        wrt_data,
    input  logic [IDX_W-1:0]         chk_rs,
    output logic                     chk_hit,
    output logic [DATA_W-1:0]        chk_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             fifo_deq;
    wb_entry_t        fifo_head;
    wb_entry_t        fifo_entries [DEPTH];
    logic [PTR_W-1:0] fifo_rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] free;
    logic             mem_en;
    logic             alu_en;
    logic             reg_write_reg;
    logic [IDX_W-1:0] rd_reg;
    logic [DATA_W-1:0] wrt_data_reg;
    logic             bypass_hit;
    logic [DATA_W-1:0] bypass_data;

    // The head always leaves this cycle when present, so its slot is reusable.
    assign free      = CNT_W'(DEPTH) - fifo_count + CNT_W'(fifo_deq);
    // Load wins the last slot; ALU only takes it when no load is competing.
    assign mem_ready = rst_n && (free >= CNT_W'(1));
    assign alu_ready = rst_n && ((free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !mem_valid));

    // x0 writes are handshaken normally but never stored.
    assign mem_en = mem_valid && mem_ready && (mem_rd != REG_ZERO);
    assign alu_en = alu_valid && alu_ready && (alu_rd != REG_ZERO);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr0_en    (mem_en),
        .wr0_entry ('{rd: mem_rd, data: mem_data}),
        .wr1_en    (alu_en),
        .wr1_entry ('{rd: alu_rd, data: alu_data}),
        .deq       (fifo_deq),
        .head      (fifo_head),
        .entries   (fifo_entries),
        .rd_ptr    (fifo_rd_ptr),
        .count     (fifo_count)
    );

    // Output stage: registered write port, index/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write_reg <= 1'b0;
            rd_reg        <= '0;
            wrt_data_reg  <= '0;
        end else if (fifo_deq) begin
            reg_write_reg <= 1'b1;
            rd_reg        <= fifo_head.rd;
            wrt_data_reg  <= fifo_head.data;
        end else begin
            reg_write_reg <= 1'b0;
        end
    end

    // Bypass: output stage is oldest, then FIFO from head to tail; later match overrides.
    always_comb begin
        bypass_hit  = 1'b0;
        bypass_data = '0;
        if (reg_write_reg && (rd_reg == chk_rs)) begin
            bypass_hit  = 1'b1;
            bypass_data = wrt_data_reg;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < fifo_count) && (fifo_entries[fifo_rd_ptr + PTR_W'(i)].rd == chk_rs)) begin
                bypass_hit  = 1'b1;
                bypass_data = fifo_entries[fifo_rd_ptr + PTR_W'(i)].data;
            end
        end
        if (chk_rs == REG_ZERO) begin
            bypass_hit  = 1'b0;
            bypass_data = '0;
        end
    end

    assign RegWrite = reg_write_reg;
    assign rd       = rd_reg;
    assign wrt_data = wrt_data_reg;
    assign chk_hit  = bypass_hit;
    assign chk_data = bypass_data;
    assign count    = fifo_count;
    assign empty    = (fifo_count == '0);
endmodule
